// File: rtl/tc_counter_load_arbiter_if.sv
// Load-request bus between four requesters and the shared-counter arbiter.
// The master side drives requests; the slave side grants and drives the counter load.
interface tc_counter_load_arbiter_if #(
    parameter int WIDTH = 8
);
    logic [3:0]         req;
    logic [4*WIDTH-1:0] data;
    logic [3:0]         ack;
    logic               save;
    logic [WIDTH-1:0]   out;
    logic               busy;

    modport master (
        output req,
        output data,
        input  ack,
        input  save,
        input  out,
        input  busy
    );

    modport slave (
        input  req,
        input  data,
        output ack,
        output save,
        output out,
        output busy
    );
endinterface

// File: rtl/tc_counter_load_arbiter.sv
// Round-robin arbiter that lets four requesters load a shared counter,
// with a fixed cool-down after each load before the next grant.
module tc_counter_load_arbiter #(
    parameter int WIDTH    = 8,
    parameter int COOLDOWN = 4
) (
    input logic                       clk,
    input logic                       rst,
    tc_counter_load_arbiter_if.slave  bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_COOL = 2'd2;

    localparam int CW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
    localparam logic [CW-1:0] COOL_INIT =
        CW'((COOLDOWN > 0) ? COOLDOWN - 1 : 0);

    logic [1:0]       state_q, state_d;
    logic [1:0]       ptr_q,   ptr_d;
    logic [CW-1:0]    cool_q,  cool_d;
    logic [3:0]       ack_q,   ack_d;
    logic             save_q,  save_d;
    logic [WIDTH-1:0] out_q,   out_d;
    logic             busy_q,  busy_d;

    logic       sel_vld;
    logic [1:0] sel_idx;
    logic [1:0] cand;

    // Walk from the far end back to ptr so the nearest requester wins.
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = ptr_q;
        cand    = '0;
        for (int k = 3; k >= 0; k--) begin
            cand = ptr_q + 2'(k);
            if (bus.req[cand]) begin
                sel_vld = 1'b1;
                sel_idx = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cool_d  = cool_q;
        ack_d   = '0;
        save_d  = 1'b0;
        out_d   = out_q;
        unique case (state_q)
            S_IDLE: begin
                if (sel_vld) begin
                    state_d = S_LOAD;
                    save_d  = 1'b1;
                    ack_d   = 4'b0001 << sel_idx;
                    out_d   = bus.data[sel_idx*WIDTH +: WIDTH];
                    ptr_d   = sel_idx + 2'd1;
                end
            end
            S_LOAD: begin
                if (COOLDOWN > 0) begin
                    state_d = S_COOL;
                    cool_d  = COOL_INIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_COOL: begin
                if (cool_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cool_d = cool_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            cool_q  <= '0;
            ack_q   <= '0;
            save_q  <= 1'b0;
            out_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cool_q  <= cool_d;
            ack_q   <= ack_d;
            save_q  <= save_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.ack  = ack_q;
    assign bus.save = save_q;
    assign bus.out  = out_q;
    assign bus.busy = busy_q;
endmodule

// File: tb/tb_tc_counter_load_arbiter.sv
// Scoreboard bench for the counter-load arbiter: default build plus a
// zero-cooldown build sharing clock and reset.
module tb_tc_counter_load_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tc_counter_load_arbiter_if #(.WIDTH(8)) bus0 ();
    tc_counter_load_arbiter_if #(.WIDTH(8)) bus1 ();

    tc_counter_load_arbiter #(.WIDTH(8), .COOLDOWN(4)) dut0 (
        .clk(clk),
        .rst(rst),
        .bus(bus0)
    );

    tc_counter_load_arbiter #(.WIDTH(8), .COOLDOWN(0)) dut1 (
        .clk(clk),
        .rst(rst),
        .bus(bus1)
    );

    int vectors = 0;
    int miscompares = 0;
    logic [11:0] exp_q[$];
    logic [11:0] e;

    task automatic wait_save(input int limit, output int n, output bit found);
        n = 0;
        found = 1'b0;
        while (!found && n < limit) begin
            @(negedge clk);
            n++;
            if (bus0.save === 1'b1) found = 1'b1;
        end
    endtask

    task automatic do_reset();
        bus0.req = 4'b0000;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus0.req  = 4'b1111;
        bus0.data = 32'h40302010;
        repeat (5) begin
            @(negedge clk);
            vectors++;
            if ({bus0.save, bus0.ack, bus0.out, bus0.busy} !== 14'd0) begin
                miscompares++;
                $display("FAIL reset_outputs: got save=%b ack=%b out=%h busy=%b want all 0",
                         bus0.save, bus0.ack, bus0.out, bus0.busy);
            end
        end
        bus0.req = 4'b0000;
        rst = 1'b0;
    endtask

    task automatic test_single();
        int n;
        bit f;
        do_reset();
        bus0.data = 32'h00800000;
        bus0.req  = 4'b0100;
        exp_q.push_back({4'b0100, 8'h80});
        wait_save(4, n, f);
        vectors++;
        if (!f || n != 1) begin
            miscompares++;
            $display("FAIL single_latency: got found=%0b cycles=%0d want 1 cycle", f, n);
        end
        e = exp_q.pop_front();
        vectors++;
        if ({bus0.ack, bus0.out} !== e) begin
            miscompares++;
            $display("FAIL single_grant: got ack=%b out=%h want ack=%b out=%h",
                     bus0.ack, bus0.out, e[11:8], e[7:0]);
        end
        bus0.req = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if (bus0.busy !== 1'b1 || bus0.save !== 1'b0 || bus0.ack !== 4'b0000 || bus0.out !== 8'h80) begin
                miscompares++;
                $display("FAIL single_cool%0d: got busy=%b save=%b ack=%b out=%h want busy=1 save=0 ack=0 out=80",
                         i, bus0.busy, bus0.save, bus0.ack, bus0.out);
            end
        end
        @(negedge clk);
        vectors++;
        if (bus0.busy !== 1'b0 || bus0.out !== 8'h80) begin
            miscompares++;
            $display("FAIL single_idle: got busy=%b out=%h want busy=0 out=80", bus0.busy, bus0.out);
        end
    endtask

    task automatic test_round_robin();
        int n;
        bit f;
        logic [7:0] vals [4] = '{8'h10, 8'h20, 8'h30, 8'h40};
        do_reset();
        bus0.data = 32'h40302010;
        bus0.req  = 4'b1111;
        for (int g = 0; g < 5; g++)
            exp_q.push_back({4'b0001 << (g % 4), vals[g % 4]});
        for (int g = 0; g < 5; g++) begin
            wait_save(10, n, f);
            vectors++;
            if (!f || n != ((g == 0) ? 1 : 6)) begin
                miscompares++;
                $display("FAIL rr_spacing%0d: got found=%0b cycles=%0d want %0d",
                         g, f, n, (g == 0) ? 1 : 6);
            end
            e = exp_q.pop_front();
            vectors++;
            if ({bus0.ack, bus0.out} !== e) begin
                miscompares++;
                $display("FAIL rr_grant%0d: got ack=%b out=%h want ack=%b out=%h",
                         g, bus0.ack, bus0.out, e[11:8], e[7:0]);
            end
        end
        bus0.req = 4'b0000;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_ptr_skip();
        int n;
        bit f;
        logic [3:0] pat [3] = '{4'b0010, 4'b0001, 4'b0011};
        do_reset();
        bus0.data = 32'h40302010;
        exp_q.push_back({4'b0010, 8'h20});
        exp_q.push_back({4'b0001, 8'h10});
        exp_q.push_back({4'b0010, 8'h20});
        bus0.req = pat[0];
        for (int g = 0; g < 3; g++) begin
            wait_save(10, n, f);
            bus0.req = (g < 2) ? pat[g+1] : 4'b0000;
            e = exp_q.pop_front();
            vectors++;
            if (!f || {bus0.ack, bus0.out} !== e) begin
                miscompares++;
                $display("FAIL skip_grant%0d: got found=%0b ack=%b out=%h want ack=%b out=%h",
                         g, f, bus0.ack, bus0.out, e[11:8], e[7:0]);
            end
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_midop_reset();
        int n;
        bit f;
        do_reset();
        bus0.data = 32'h40302010;
        bus0.req  = 4'b0100;
        exp_q.push_back({4'b0100, 8'h30});
        wait_save(4, n, f);
        bus0.req = 4'b0000;
        e = exp_q.pop_front();
        vectors++;
        if (!f || {bus0.ack, bus0.out} !== e) begin
            miscompares++;
            $display("FAIL midrst_first: got found=%0b ack=%b out=%h want ack=%b out=%h",
                     f, bus0.ack, bus0.out, e[11:8], e[7:0]);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus0.busy !== 1'b0 || bus0.save !== 1'b0 || bus0.ack !== 4'b0000 || bus0.out !== 8'h00) begin
            miscompares++;
            $display("FAIL midrst_abort: got busy=%b save=%b ack=%b out=%h want 0/0/0/00",
                     bus0.busy, bus0.save, bus0.ack, bus0.out);
        end
        rst = 1'b0;
        bus0.req = 4'b1100;
        exp_q.push_back({4'b0100, 8'h30});
        wait_save(4, n, f);
        bus0.req = 4'b0000;
        e = exp_q.pop_front();
        vectors++;
        if (!f || n != 1 || {bus0.ack, bus0.out} !== e) begin
            miscompares++;
            $display("FAIL midrst_regrant: got found=%0b cycles=%0d ack=%b out=%h want ack=%b out=%h",
                     f, n, bus0.ack, bus0.out, e[11:8], e[7:0]);
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_cooldown0();
        logic exp_save;
        bus1.data = 32'h0000005A;
        bus1.req  = 4'b0001;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            exp_save = (i % 2 == 0);
            vectors++;
            if (bus1.save !== exp_save || bus1.busy !== exp_save ||
                bus1.ack !== (exp_save ? 4'b0001 : 4'b0000) || bus1.out !== 8'h5A) begin
                miscompares++;
                $display("FAIL cd0_cycle%0d: got save=%b busy=%b ack=%b out=%h want save=%b busy=%b out=5a",
                         i, bus1.save, bus1.busy, bus1.ack, bus1.out, exp_save, exp_save);
            end
        end
        bus1.req = 4'b0000;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        bus0.req  = 4'b0000;
        bus0.data = '0;
        bus1.req  = 4'b0000;
        bus1.data = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_ptr_skip();
        test_midop_reset();
        test_cooldown0();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/tc_counter_load_arbiter.md
TC_COUNTER_LOAD_ARBITER -- requirements
Module: tc_counter_load_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8: width of the counter load value.
REQ-002 SHALL have parameter COOLDOWN, default 4: minimum run cycles after a load before the next arbitration (0 allowed).
REQ-003 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-005 SHALL have port req  input  4: per-requester load request; level, held until ack.
REQ-006 SHALL have port data  input  4*WIDTH: requester i load value in bits [i*WIDTH +: WIDTH].
REQ-007 SHALL have port ack  output  4: one-hot, one-cycle pulse to the requester whose value is loaded.
REQ-008 SHALL have port save  output  1: load strobe to the shared counter's save input.
REQ-009 SHALL have port out  output  WIDTH: load value to the shared counter's in input.
REQ-010 SHALL have port busy  output  1: high whenever state is not IDLE.

Function
REQ-011 SHALL implement FSM states IDLE, LOAD, COOL; all outputs registered.
REQ-012 IDLE: if req != 0, SHALL select the first asserted requester at or after round-robin pointer ptr (wrapping 3->0), capture its index and data slice, and go to LOAD; else stay IDLE.
REQ-013 LOAD (exactly one cycle): save=1, out=captured value, ack[captured index]=1, ptr <= index+1 mod 4.
REQ-014 From LOAD, SHALL go to COOL with cool counter = COOLDOWN-1 if COOLDOWN>0, else directly to IDLE.
REQ-015 COOL: counter decrements each cycle; at 0 SHALL go to IDLE; stays exactly COOLDOWN cycles.
REQ-016 Latency: req sampled high in IDLE at edge n -> save/ack high in cycle n+1.
REQ-017 Continuous requests SHALL yield one save every COOLDOWN+2 cycles.
REQ-018 save, ack SHALL be 0 outside LOAD; out SHALL hold its last loaded value outside LOAD.
REQ-019 Data SHALL be captured in IDLE only; changes to data or req after capture do not affect the pending load (dropping req before ack still completes the load).
REQ-020 req changes during LOAD/COOL SHALL be ignored until the next IDLE cycle.
REQ-021 Round-robin SHALL guarantee that, with all four requesting, grant order is 0,1,2,3,0,...
REQ-022 Cool counter width SHALL accommodate COOLDOWN without overflow; COOLDOWN=0 SHALL never enter COOL.

Reset
REQ-023 rst high at an edge SHALL force state=IDLE, ptr=0, cool=0, save=0, ack=0, out=0, busy=0, regardless of current state.
REQ-024 Reset during LOAD or COOL SHALL abort the operation; aborted requester receives no further ack.
REQ-025 First arbitration after reset release SHALL start from requester 0.

Verification
REQ-026 Reset: rst held 5 cycles with req=4'b1111 -> save=0, ack=0, out=0, busy=0 throughout.
REQ-027 Single request: req=4'b0100, data slice 2 = 8'h80 -> next cycle save=1, out=8'h80, ack=4'b0100; busy=1 for 1+4 cycles; then IDLE.
REQ-028 Round robin: req=4'b1111 held, distinct data 8'h10/8'h20/8'h30/8'h40 -> acks 0,1,2,3,0 in order, saves spaced 6 cycles, out matches each slice.
REQ-029 Pointer skip: after grant to 1, req=4'b0001 only -> grant 0 (wrap), next pointer 1.
REQ-030 Mid-op reset: rst pulsed in COOL after grant 2 -> busy=0 next cycle; with req=4'b1100 next grant is 2, not 3.
REQ-031 COOLDOWN=0 build: req=4'b0001 held -> save pulses every 2 cycles, busy never in COOL.
